// File: rtl/cpld_spi_regs_pkg.sv
// Shared constants for the CPLD SPI register responder: register map
// addresses, frame geometry and a small address-decode helper.
package cpld_spi_regs_pkg;

  localparam logic [6:0] ADDR_ID    = 7'h00;
  localparam logic [6:0] ADDR_STAT0 = 7'h01;
  localparam logic [6:0] ADDR_STAT1 = 7'h02;
  localparam logic [6:0] ADDR_CTRL0 = 7'h10;
  localparam logic [6:0] ADDR_CTRL1 = 7'h11;
  localparam logic [6:0] ADDR_CTRL2 = 7'h12;
  localparam logic [6:0] ADDR_CTRL3 = 7'h13;

  // A complete frame is 16 SCLK rising edges; the counter parks at 17 so
  // any over-long frame stays distinguishable from a good one.
  localparam logic [4:0] FRAME_BITS  = 5'd16;
  localparam logic [4:0] BIT_CNT_MAX = 5'd17;
  // Count value just before the rising edge that completes R/nW + address.
  localparam logic [4:0] HDR_LAST    = 5'd7;
  localparam int         RW_BIT      = 15;

  // Writable control bytes live at 0x10..0x13.
  function automatic logic is_ctrl_addr(input logic [6:0] addr);
    return (addr[6:2] == ADDR_CTRL0[6:2]);
  endfunction

endpackage

// File: rtl/cpld_spi_regs_sync.sv
// N-stage flip-flop synchroniser with asynchronous active-low reset and a
// selectable reset level (chip selects must reset to their idle-high level).
module cpld_spi_regs_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {STAGES{RESET_VAL}};
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/cpld_spi_regs.sv
// SPI Mode-0 target exposing CPLD status and control registers to the DSP.
// All SPI pins are synchronised into sysclk and edge-detected, so SCLK must
// stay at or below sysclk/8. Frame: R/nW, 7-bit address, 8-bit data, MSB first.
// Writes commit only on the chip-select rising edge of an exact 16-bit frame.
module cpld_spi_regs
  import cpld_spi_regs_pkg::*;
#(
  parameter logic [7:0]        DEVICE_ID   = 8'hA5,
  parameter int                STATUS_W    = 16,
  parameter int                CTRL_W      = 32,
  parameter logic [CTRL_W-1:0] CTRL_RESET  = '0,
  parameter int                SYNC_STAGES = 2
) (
  input  logic                sysclk,
  input  logic                reset_INV,
  input  logic                spi_clk,
  input  logic                spi_cs_INV,
  input  logic                spi_mosi,
  output logic                spi_miso,
  input  logic [STATUS_W-1:0] status_in,
  output logic [CTRL_W-1:0]   ctrl_out,
  output logic                wr_strobe,
  output logic [6:0]          wr_addr,
  output logic                frame_error
);

  logic w_clk_s, w_cs_s, w_mosi_s;
  logic r_clk_d, r_cs_d;
  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

  logic [4:0]        r_bit_cnt;
  logic [15:0]       r_shift_in;
  logic [7:0]        r_shift_out;
  logic              r_miso;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_wr_strobe;
  logic [6:0]        r_wr_addr;
  logic              r_frame_error;

  logic [15:0] w_shift_next;
  logic [6:0]  w_hdr_addr;
  logic        w_hdr_read;
  logic [7:0]  w_rd_byte;
  logic        w_frm_read;
  logic [6:0]  w_frm_addr;
  logic [7:0]  w_frm_data;

  cpld_spi_regs_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .clk(sysclk), .rst_n(reset_INV), .i_d(spi_clk), .o_q(w_clk_s)
  );
  cpld_spi_regs_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(sysclk), .rst_n(reset_INV), .i_d(spi_cs_INV), .o_q(w_cs_s)
  );
  cpld_spi_regs_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(sysclk), .rst_n(reset_INV), .i_d(spi_mosi), .o_q(w_mosi_s)
  );

  // Remember last synchronised SCLK/CS levels for edge detection.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      r_clk_d <= 1'b0;
      r_cs_d  <= 1'b1;
    end else begin
      r_clk_d <= w_clk_s;
      r_cs_d  <= w_cs_s;
    end
  end

  assign w_sclk_rise = w_clk_s & ~r_clk_d;
  assign w_sclk_fall = ~w_clk_s & r_clk_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;

  // Header view as it will look after the current rising edge is shifted in.
  assign w_shift_next = {r_shift_in[14:0], w_mosi_s};
  assign w_hdr_read   = w_shift_next[7];
  assign w_hdr_addr   = w_shift_next[6:0];

  // Completed-frame fields, valid when exactly 16 bits were received.
  assign w_frm_read = r_shift_in[RW_BIT];
  assign w_frm_addr = r_shift_in[14:8];
  assign w_frm_data = r_shift_in[7:0];

  // Read map; status bytes are snapshotted when this value is loaded.
  always_comb begin
    w_rd_byte = 8'h00;
    case (w_hdr_addr)
      ADDR_ID:    w_rd_byte = DEVICE_ID;
      ADDR_STAT0: w_rd_byte = status_in[7:0];
      ADDR_STAT1: w_rd_byte = status_in[15:8];
      ADDR_CTRL0: w_rd_byte = r_ctrl[7:0];
      ADDR_CTRL1: w_rd_byte = r_ctrl[15:8];
      ADDR_CTRL2: w_rd_byte = r_ctrl[23:16];
      ADDR_CTRL3: w_rd_byte = r_ctrl[31:24];
      default:    w_rd_byte = 8'h00;
    endcase
  end

  // Frame engine: CS edges take priority over SCLK edges in the same cycle.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      r_bit_cnt     <= '0;
      r_shift_in    <= '0;
      r_shift_out   <= '0;
      r_miso        <= 1'b0;
      r_ctrl        <= CTRL_RESET;
      r_wr_strobe   <= 1'b0;
      r_wr_addr     <= '0;
      r_frame_error <= 1'b0;
    end else begin
      r_wr_strobe   <= 1'b0;
      r_frame_error <= 1'b0;
      if (w_cs_rise) begin
        r_miso      <= 1'b0;
        r_shift_out <= '0;
        if (r_bit_cnt == FRAME_BITS) begin
          if (!w_frm_read) begin
            r_wr_strobe <= 1'b1;
            r_wr_addr   <= w_frm_addr;
            if (is_ctrl_addr(w_frm_addr)) begin
              for (int b = 0; b < 4; b++) begin
                if (w_frm_addr[1:0] == b[1:0]) r_ctrl[8*b +: 8] <= w_frm_data;
              end
            end
          end
        end else if (r_bit_cnt != 5'd0) begin
          r_frame_error <= 1'b1;
        end
      end else if (w_cs_fall) begin
        r_bit_cnt   <= '0;
        r_shift_in  <= '0;
        r_shift_out <= '0;
        r_miso      <= 1'b0;
      end else if (w_cs_s) begin
        r_miso <= 1'b0;
      end else if (w_sclk_rise) begin
        r_shift_in <= w_shift_next;
        if (r_bit_cnt != BIT_CNT_MAX) r_bit_cnt <= r_bit_cnt + 5'd1;
        if (r_bit_cnt == HDR_LAST && w_hdr_read) r_shift_out <= w_rd_byte;
      end else if (w_sclk_fall) begin
        r_miso      <= r_shift_out[7];
        r_shift_out <= {r_shift_out[6:0], 1'b0};
      end
    end
  end

  assign spi_miso    = r_miso;
  assign ctrl_out    = r_ctrl;
  assign wr_strobe   = r_wr_strobe;
  assign wr_addr     = r_wr_addr;
  assign frame_error = r_frame_error;

endmodule
